// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg : shared definitions for the 5..8 stage MIPS pipeline controller.
//   - stage index constants for the fixed front of the pipe (IF, ID, EX)
//   - controller state encoding
//   - scoreboard entry carried alongside each stage from EX onwards
// No ports (package).
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int IF_S = 0;
    localparam int ID_S = 1;
    localparam int EX_S = 2;

    // Scoreboard destination field is sized for the widest register index
    // supported; narrower REG_W values are zero-extended into it.
    localparam int SB_DST_W = 8;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        SVC     = 2'd2,
        RELEASE = 2'd3
    } pipe_state_e;

    typedef struct packed {
        logic [SB_DST_W-1:0] dst;
        logic                regwrite;
        logic                memread;
        logic                syscall;
    } sb_entry_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if : handshake/bus bundle between the datapath and pipe_ctrl.
//   master : datapath side, drives ID decode info, redirect, memory busy,
//            syscall completion; observes valids, advances and control pulses.
//   slave  : pipe_ctrl side.
// Parameters NSTAGES / REG_W must match the attached pipe_ctrl instance.
// ---------------------------------------------------------------------------
interface pipe_ctrl_if #(
    parameter int NSTAGES = 5,
    parameter int REG_W   = 5
);
    logic               fetch_valid_i;
    logic [REG_W-1:0]   id_rs_i;
    logic [REG_W-1:0]   id_rt_i;
    logic               id_use_rs_i;
    logic               id_use_rt_i;
    logic [REG_W-1:0]   id_dst_i;
    logic               id_regwrite_i;
    logic               id_memread_i;
    logic               id_syscall_i;
    logic               ex_redirect_i;
    logic               mem_busy_i;
    logic               syscall_done_i;

    logic [NSTAGES-1:0] stage_valid_o;
    logic [NSTAGES-1:0] stage_advance_o;
    logic               pc_enable_o;
    logic               flush_if_id_o;
    logic               bubble_id_ex_o;
    logic               load_hazard_o;
    logic               syscall_req_o;
    logic               writeback_flag_o;

    modport master (
        output fetch_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_dst_i, id_regwrite_i, id_memread_i, id_syscall_i,
               ex_redirect_i, mem_busy_i, syscall_done_i,
        input  stage_valid_o, stage_advance_o, pc_enable_o, flush_if_id_o,
               bubble_id_ex_o, load_hazard_o, syscall_req_o, writeback_flag_o
    );

    modport slave (
        input  fetch_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_dst_i, id_regwrite_i, id_memread_i, id_syscall_i,
               ex_redirect_i, mem_busy_i, syscall_done_i,
        output stage_valid_o, stage_advance_o, pc_enable_o, flush_if_id_o,
               bubble_id_ex_o, load_hazard_o, syscall_req_o, writeback_flag_o
    );
endinterface

// File: rtl/pipe_ctrl_scoreboard.sv
// ---------------------------------------------------------------------------
// pipe_scoreboard : per-stage destination scoreboard for stages EX..WB plus
// the load-use hazard compare against the instruction in ID.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   advance[k]      stage k register loads this cycle (k = EX..WB)
//   fill[k]         the value loaded into stage k is a real instruction
//   id_entry        decode info of the ID instruction (enters EX)
//   id_valid        ID holds a real instruction
//   rs/rt/use_*     ID source operands
//   load_hazard     a load in EX..EX+LOAD_LAT-1 feeds an ID source
//   wb_syscall      entry in WB is a syscall
// Entries are zeroed whenever a bubble enters, so a set bit implies a valid
// stage and no separate valid qualification is needed here.
// ---------------------------------------------------------------------------
module pipe_scoreboard
    import mips_pkg::*;
#(
    parameter int NSTAGES  = 5,
    parameter int LOAD_LAT = 1,
    parameter int REG_W    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NSTAGES-1:EX_S] advance,
    input  logic [NSTAGES-1:EX_S] fill,
    input  sb_entry_t             id_entry,
    input  logic                  id_valid,
    input  logic [REG_W-1:0]      rs,
    input  logic [REG_W-1:0]      rt,
    input  logic                  use_rs,
    input  logic                  use_rt,
    output logic                  load_hazard,
    output logic                  wb_syscall
);

    sb_entry_t sb       [NSTAGES-1:EX_S];
    sb_entry_t shift_in [NSTAGES-1:EX_S];

    logic [SB_DST_W-1:0] rs_ext;
    logic [SB_DST_W-1:0] rt_ext;

    always_comb begin
        shift_in[EX_S] = id_entry;
        for (int k = EX_S + 1; k < NSTAGES; k++) begin
            shift_in[k] = sb[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = EX_S; k < NSTAGES; k++) begin
                sb[k] <= '0;
            end
        end else begin
            for (int k = EX_S; k < NSTAGES; k++) begin
                if (advance[k]) begin
                    sb[k] <= fill[k] ? shift_in[k] : '0;
                end
            end
        end
    end

    // Load data becomes forwardable once the load has moved LOAD_LAT stages
    // past EX, so only stages EX..EX+LOAD_LAT-1 can interlock.
    always_comb begin
        rs_ext      = SB_DST_W'(rs);
        rt_ext      = SB_DST_W'(rt);
        load_hazard = 1'b0;
        for (int k = EX_S; k <= 1 + LOAD_LAT; k++) begin
            if (sb[k].memread && sb[k].regwrite && (sb[k].dst != '0) &&
                ((use_rs && (sb[k].dst == rs_ext)) ||
                 (use_rt && (sb[k].dst == rt_ext)))) begin
                load_hazard = id_valid;
            end
        end
    end

    assign wb_syscall = sb[NSTAGES-1].syscall;

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl : pipeline control unit for the MIPS core.
// Owns a valid bit per stage and a destination scoreboard, and produces the
// per-stage load enables, PC enable, IF/ID flush and ID/EX bubble.
// Ports:
//   clk    clock
//   reset  synchronous active-low reset
//   bus    pipe_ctrl_if.slave: ID decode info, redirect, mem busy, syscall
//          handshake in; stage valids/advances, flush, bubble, hazard,
//          syscall request and writeback flag out.
// Stage indices: 0=IF, 1=ID, 2=EX, MEM_STAGE=MEM, NSTAGES-1=WB.
// ---------------------------------------------------------------------------
module pipe_ctrl
    import mips_pkg::*;
#(
    parameter int NSTAGES   = 5,
    parameter int MEM_STAGE = 3,
    parameter int LOAD_LAT  = 1,
    parameter int REG_W     = 5
) (
    input  logic      clk,
    input  logic      reset,
    pipe_ctrl_if.slave bus
);

    localparam int WB_S = NSTAGES - 1;

    localparam logic [1:0] ST_RUN     = RUN;
    localparam logic [1:0] ST_DRAIN   = DRAIN;
    localparam logic [1:0] ST_SVC     = SVC;
    localparam logic [1:0] ST_RELEASE = RELEASE;

    logic [1:0]         state;
    logic [NSTAGES-1:0] valid;
    logic [NSTAGES-1:0] frz;
    logic [NSTAGES-1:0] adv;
    logic [NSTAGES-1:0] in_valid;
    logic               hazard;
    logic               wb_syscall;
    logic               sys_in_id;
    logic               sys_hold;
    logic               id_hold;
    logic               redirect;
    logic               drained;
    sb_entry_t          id_entry;

    always_comb begin
        sys_in_id = valid[ID_S] & bus.id_syscall_i;
        // EX only moves while memory is not busy, so a redirect waits for it.
        redirect  = reset & bus.ex_redirect_i & valid[EX_S] & ~bus.mem_busy_i;
        sys_hold  = ((state == ST_RUN) & sys_in_id) |
                    (state == ST_DRAIN) | (state == ST_SVC);
        // A taken redirect kills ID, so any ID-side hold it caused goes too.
        id_hold   = (hazard | sys_hold) & ~redirect;

        for (int i = 0; i < NSTAGES; i++) begin
            frz[i] = (bus.mem_busy_i & (i <= MEM_STAGE)) | ((i <= ID_S) & id_hold);
        end

        // What each stage register would load: a bubble when the feeding
        // stage is held or killed by a redirect.
        in_valid[IF_S] = bus.fetch_valid_i;
        for (int i = 1; i < NSTAGES; i++) begin
            in_valid[i] = valid[i-1] & ~frz[i-1] & ~(redirect & (i <= EX_S));
        end

        adv     = reset ? ~frz : '0;
        drained = ~|valid[WB_S:EX_S];

        id_entry.dst      = SB_DST_W'(bus.id_dst_i);
        id_entry.regwrite = bus.id_regwrite_i;
        id_entry.memread  = bus.id_memread_i;
        id_entry.syscall  = bus.id_syscall_i;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= '0;
        end else begin
            for (int i = 0; i < NSTAGES; i++) begin
                if (adv[i]) begin
                    valid[i] <= in_valid[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (sys_in_id && !redirect) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // An older redirect kills the waiting syscall.
                    if (redirect)     state <= ST_RUN;
                    else if (drained) state <= ST_SVC;
                end
                ST_SVC: begin
                    if (bus.syscall_done_i) state <= ST_RELEASE;
                end
                default: begin
                    // Leave only once the syscall has actually entered EX;
                    // otherwise RUN would see it in ID again and re-drain.
                    if (!frz[EX_S]) state <= ST_RUN;
                end
            endcase
        end
    end

    pipe_scoreboard #(
        .NSTAGES  (NSTAGES),
        .LOAD_LAT (LOAD_LAT),
        .REG_W    (REG_W)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .advance     (adv[NSTAGES-1:EX_S]),
        .fill        (in_valid[NSTAGES-1:EX_S]),
        .id_entry    (id_entry),
        .id_valid    (valid[ID_S]),
        .rs          (bus.id_rs_i),
        .rt          (bus.id_rt_i),
        .use_rs      (bus.id_use_rs_i),
        .use_rt      (bus.id_use_rt_i),
        .load_hazard (hazard),
        .wb_syscall  (wb_syscall)
    );

    assign bus.stage_valid_o    = valid;
    assign bus.stage_advance_o  = adv;
    assign bus.pc_enable_o      = reset & (~frz[IF_S] | redirect);
    assign bus.flush_if_id_o    = redirect;
    assign bus.bubble_id_ex_o   = reset & frz[ID_S] & ~frz[EX_S];
    assign bus.load_hazard_o    = reset & hazard;
    assign bus.syscall_req_o    = reset & (state == ST_SVC);
    assign bus.writeback_flag_o = reset & valid[WB_S] & wb_syscall;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline control unit for the 5-stage MIPS core; successor to the fixed stall/flush logic.
- Owns a valid bit per stage and a destination-register scoreboard per stage. Generates per-stage advance enables, PC enable, IF/ID flush and ID/EX bubble.
- Covers load-use interlock with configurable load latency, memory-busy freeze, EX-resolved redirect, and syscall drain/handshake.
- Sits beside the datapath; pipeline registers load only when their advance bit is set.

Parameters:
NSTAGES, 5, number of stages (5..8); index 0=IF, 1=ID, 2=EX, NSTAGES-1=WB
MEM_STAGE, 3, index of memory stage (2 < MEM_STAGE < NSTAGES-1)
LOAD_LAT, 1, stages after EX before load data is forwardable (1..MEM_STAGE-1)
REG_W, 5, register index width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
fetch_valid_i  in  1  IF holds a real instruction
id_rs_i  in  REG_W  ID source rs
id_rt_i  in  REG_W  ID source rt
id_use_rs_i  in  1  ID reads rs
id_use_rt_i  in  1  ID reads rt
id_dst_i  in  REG_W  ID destination register
id_regwrite_i  in  1  ID writes a register
id_memread_i  in  1  ID is a load
id_syscall_i  in  1  ID is a syscall
ex_redirect_i  in  1  EX branch taken / jump; held by source while EX frozen
mem_busy_i  in  1  memory stage not complete this cycle
syscall_done_i  in  1  host finished syscall service
stage_valid_o  out  NSTAGES  per-stage valid
stage_advance_o  out  NSTAGES  load enable for register feeding stage i
pc_enable_o  out  1  PC may update
flush_if_id_o  out  1  IF/ID register loads a bubble
bubble_id_ex_o  out  1  ID/EX register loads a bubble
load_hazard_o  out  1  load-use interlock active
syscall_req_o  out  1  pipeline drained, syscall awaiting service
writeback_flag_o  out  1  one-cycle pulse when the syscall instruction is valid in WB

Behaviour:
- Reset (reset==0 at clk edge):
  - stage_valid_o=0, scoreboard cleared, state=RUN, all pulses 0.
  - While reset is low: pc_enable_o=0, stage_advance_o=0.
- Scoreboard per stage k>=2 holds {dst, regwrite, memread, syscall}. It shifts with valid on advance; bubbles clear the entry.
- load_hazard_o: any valid stage k in [2, 1+LOAD_LAT] has memread & regwrite & dst!=0, and dst equals rs (with use_rs) or rt (with use_rt) of a valid ID instruction. Register 0 never hazards.
- Freeze terms (frz[i]=1 means stage i holds):
  - mem_busy_i freezes stages 0..MEM_STAGE.
  - load_hazard_o or state!=RUN-release freezes stages 0..1.
- stage_advance_o[i] = ~frz[i]. When frz[i-1] & ~frz[i], stage i receives a bubble (valid 0). bubble_id_ex_o = frz[1] & ~frz[2].
- Redirect: taken only when ex_redirect_i and stage 2 valid and ~frz[2].
  - Kills stages 0 and 1: next valid[1]=0 and flush_if_id_o=1.
  - pc_enable_o=1 that cycle, even if a load hazard is active; the hazard is discarded with the killed ID instruction.
- pc_enable_o = ~frz[0] | redirect-taken.
- State machine:
  - RUN: valid ID syscall → DRAIN. ID/IF frozen from that cycle.
  - DRAIN: insert bubbles until stages 2..NSTAGES-1 are all invalid, then → SVC.
  - SVC: syscall_req_o=1. On syscall_done_i → RELEASE.
  - RELEASE: one cycle; syscall advances into EX, IF/ID unfrozen; → RUN.
- Redirect from an older instruction while in DRAIN kills the syscall; return to RUN next cycle with syscall_req_o never asserted.
- mem_busy_i during DRAIN: remain in DRAIN.
- writeback_flag_o = valid[WB] & scoreboard syscall bit.
- Latency: a bubble inserted at ID/EX reaches WB after NSTAGES-3 further cycles.
- Simultaneous mem_busy and redirect: redirect deferred until EX advances.
- Reset mid-DRAIN or mid-SVC returns immediately to RUN, empty.

Decomposition:
- Shared package mips_pkg:
  - stage index constants IF_S/ID_S/EX_S.
  - state enum {RUN, DRAIN, SVC, RELEASE}.
  - scoreboard entry struct.
- One sub-module, pipe_scoreboard: shift array of entries plus hazard compare.

Test Plan:
- Reset then fetch_valid_i=1 for 6 cycles → stage_valid_o fills 00001→11111 one bit per cycle. pc_enable_o=1 throughout.
- lw $8 in ID, next add reads $8 (LOAD_LAT=1) → load_hazard_o=1 for exactly 1 cycle, bubble_id_ex_o=1, pc_enable_o=0. Bubble seen in WB 3 cycles later. Same test with dst=$0 → no stall.
- ex_redirect_i with stage 2 valid → flush_if_id_o=1. Next cycle valid[1]=0 and valid[2]=0.
- mem_busy_i high 3 cycles with redirect in EX → stages 0..3 held, WB receives bubbles. Redirect is taken only on the cycle mem_busy_i drops.
- syscall in ID behind 3 valid instructions → DRAIN for 3 cycles, syscall_req_o rises. syscall_done_i → RELEASE. writeback_flag_o pulses 3 cycles after release (NSTAGES=5).
- NSTAGES=7, MEM_STAGE=4, LOAD_LAT=2, load followed by a dependent instruction → 2 stall cycles. Reset asserted during SVC → all valid 0 and state RUN next cycle.
